// File: rtl/mdu_sequencer_if.sv
// rtl/mdu_sequencer_if.sv - E-stage MDU request/response bundle between pipeline and sequencer
interface mdu_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             op_valid;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             stall_o;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output op_valid, op, rs_val, rt_val,
    input  stall_o, busy_o, done_o, rd_data, hi_o, lo_o
  );

  modport slave (
    input  op_valid, op, rs_val, rt_val,
    output stall_o, busy_o, done_o, rd_data, hi_o, lo_o
  );
endinterface

// File: rtl/mdu_sequencer.sv
// rtl/mdu_sequencer.sv - multi-cycle MULT/DIV sequencer owning HI/LO for the E stage
// Results are computed at accept and held in pending regs; a counter models latency.
module mdu_sequencer #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic          clk,
  input logic          rst_n,
  mdu_sequencer_if.slave bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MFHI  = 3'd6;
  localparam logic [2:0] OP_MFLO  = 3'd7;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   pend_hi_q, pend_hi_d;
  logic [WIDTH-1:0]   pend_lo_q, pend_lo_d;
  logic               pend_wr_q, pend_wr_d;
  logic               done_q, done_d;

  logic               busy;
  logic               accept;

  // Datapath: single 2W-bit multiplier on sign/zero-extended operands
  logic               is_signed;
  logic [2*WIDTH-1:0] ext_a;
  logic [2*WIDTH-1:0] ext_b;
  logic [2*WIDTH-1:0] prod;
  logic               neg_a;
  logic               neg_b;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH-1:0]   uquot;
  logic [WIDTH-1:0]   urem;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;
  logic               div_zero;

  assign busy   = (state_q == BUSY);
  assign accept = bus.op_valid & ~busy;

  always_comb begin
    is_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    ext_a     = {{WIDTH{is_signed & bus.rs_val[WIDTH-1]}}, bus.rs_val};
    ext_b     = {{WIDTH{is_signed & bus.rt_val[WIDTH-1]}}, bus.rt_val};
    prod      = ext_a * ext_b;
  end

  // Magnitude divide then re-sign; the most negative dividend over -1 wraps to itself.
  always_comb begin
    neg_a    = is_signed & bus.rs_val[WIDTH-1];
    neg_b    = is_signed & bus.rt_val[WIDTH-1];
    abs_a    = neg_a ? (~bus.rs_val + 1'b1) : bus.rs_val;
    abs_b    = neg_b ? (~bus.rt_val + 1'b1) : bus.rt_val;
    div_zero = (bus.rt_val == '0);
    uquot    = '0;
    urem     = '0;
    if (!div_zero) begin
      uquot = abs_a / abs_b;
      urem  = abs_a % abs_b;
    end
    quot = (neg_a ^ neg_b) ? (~uquot + 1'b1) : uquot;
    rem  = neg_a ? (~urem + 1'b1) : urem;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          unique case (bus.op)
            OP_MULT, OP_MULTU: begin
              pend_hi_d = prod[2*WIDTH-1:WIDTH];
              pend_lo_d = prod[WIDTH-1:0];
              pend_wr_d = 1'b1;
              cnt_d     = CNT_W'(MULT_CYCLES);
              state_d   = BUSY;
            end
            OP_DIV, OP_DIVU: begin
              pend_hi_d = rem;
              pend_lo_d = quot;
              pend_wr_d = ~div_zero;
              cnt_d     = CNT_W'(DIV_CYCLES);
              state_d   = BUSY;
            end
            OP_MTHI: hi_d = bus.rs_val;
            OP_MTLO: lo_d = bus.rs_val;
            default: ;
          endcase
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
      done_q    <= done_d;
    end
  end

  assign bus.stall_o = bus.op_valid & busy;
  assign bus.busy_o  = busy;
  assign bus.done_o  = done_q;
  assign bus.hi_o    = hi_q;
  assign bus.lo_o    = lo_q;
  assign bus.rd_data = !accept             ? '0   :
                       (bus.op == OP_MFHI) ? hi_q :
                       (bus.op == OP_MFLO) ? lo_q : '0;

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb/tb_mdu_sequencer.sv - directed self-checking bench for mdu_sequencer
module tb_mdu_sequencer;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  mdu_sequencer_if #(.WIDTH(32)) bus ();

  mdu_sequencer #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    bus.op_valid = v;
    bus.op       = o;
    bus.rs_val   = a;
    bus.rt_val   = b;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    #1;
    tests++; if (bus.hi_o !== 32'h0)  begin fails++; $display("FAIL reset_hi: got %h expected 00000000", bus.hi_o); end
    tests++; if (bus.lo_o !== 32'h0)  begin fails++; $display("FAIL reset_lo: got %h expected 00000000", bus.lo_o); end
    tests++; if (bus.busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", bus.busy_o); end
    tests++; if (bus.done_o !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", bus.done_o); end
    tests++; if (bus.stall_o !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b expected 0", bus.stall_o); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_arith();
    logic [2:0]  t_op [10];
    logic [31:0] t_a  [10];
    logic [31:0] t_b  [10];
    logic [31:0] t_hi [10];
    logic [31:0] t_lo [10];
    int n;
    t_op = '{3'd0, 3'd1, 3'd0, 3'd1, 3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd2};
    t_a  = '{32'h3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h7, 32'hFFFFFFF9, 32'h80000000, 32'hFFFFFFFF, 32'h7, 32'h5};
    t_b  = '{32'hFFFFFFFE, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h2, 32'hFFFFFFFF, 32'h10, 32'h0, 32'h0};
    t_hi = '{32'hFFFFFFFF, 32'h1, 32'h0, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFF, 32'h0, 32'hF, 32'hF, 32'hF};
    t_lo = '{32'hFFFFFFFA, 32'hFFFFFFFE, 32'h1, 32'h1, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000, 32'h0FFFFFFF, 32'h0FFFFFFF, 32'h0FFFFFFF};
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, t_op[k], t_a[k], t_b[k]);
      tests++; if (bus.stall_o !== 1'b0) begin fails++; $display("FAIL arith_accept_stall[%0d]: got %b expected 0", k, bus.stall_o); end
      tick();
      drive(1'b0, 3'd0, 32'h0, 32'h0);
      n = (t_op[k] < 3'd2) ? 5 : 10;
      for (int c = 0; c < n; c++) begin
        tests++; if (bus.busy_o !== 1'b1 || bus.done_o !== 1'b0) begin fails++; $display("FAIL arith_busy[%0d][%0d]: got busy=%b done=%b expected busy=1 done=0", k, c, bus.busy_o, bus.done_o); end
        tick();
      end
      tests++; if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b1) begin fails++; $display("FAIL arith_finish[%0d]: got busy=%b done=%b expected busy=0 done=1", k, bus.busy_o, bus.done_o); end
      tests++; if (bus.hi_o !== t_hi[k]) begin fails++; $display("FAIL arith_hi[%0d]: got %h expected %h", k, bus.hi_o, t_hi[k]); end
      tests++; if (bus.lo_o !== t_lo[k]) begin fails++; $display("FAIL arith_lo[%0d]: got %h expected %h", k, bus.lo_o, t_lo[k]); end
      tick();
      tests++; if (bus.done_o !== 1'b0) begin fails++; $display("FAIL arith_done_pulse[%0d]: got %b expected 0", k, bus.done_o); end
    end
  endtask

  task automatic test_mf_stall();
    drive(1'b1, 3'd2, 32'd100, 32'd7);
    tick();
    drive(1'b1, 3'd7, 32'h0, 32'h0);
    for (int c = 0; c < 10; c++) begin
      tests++; if (bus.stall_o !== 1'b1) begin fails++; $display("FAIL mf_stall[%0d]: got %b expected 1", c, bus.stall_o); end
      tests++; if (bus.rd_data !== 32'h0) begin fails++; $display("FAIL mf_rd_stalled[%0d]: got %h expected 00000000", c, bus.rd_data); end
      tick();
    end
    tests++; if (bus.stall_o !== 1'b0) begin fails++; $display("FAIL mf_stall_release: got %b expected 0", bus.stall_o); end
    tests++; if (bus.rd_data !== 32'hE) begin fails++; $display("FAIL mflo_new: got %h expected 0000000e", bus.rd_data); end
    tick();
    drive(1'b1, 3'd6, 32'h0, 32'h0);
    tests++; if (bus.rd_data !== 32'h2) begin fails++; $display("FAIL mfhi: got %h expected 00000002", bus.rd_data); end
    drive(1'b0, 3'd6, 32'h0, 32'h0);
    tests++; if (bus.rd_data !== 32'h0) begin fails++; $display("FAIL mf_not_valid: got %h expected 00000000", bus.rd_data); end
  endtask

  task automatic test_mt();
    drive(1'b1, 3'd4, 32'h12345678, 32'h0);
    tests++; if (bus.stall_o !== 1'b0) begin fails++; $display("FAIL mthi_stall: got %b expected 0", bus.stall_o); end
    tick();
    drive(1'b1, 3'd5, 32'h9ABCDEF0, 32'h0);
    tests++; if (bus.hi_o !== 32'h12345678) begin fails++; $display("FAIL mthi_hi: got %h expected 12345678", bus.hi_o); end
    tests++; if (bus.busy_o !== 1'b0) begin fails++; $display("FAIL mthi_busy: got %b expected 0", bus.busy_o); end
    tick();
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    tests++; if (bus.lo_o !== 32'h9ABCDEF0) begin fails++; $display("FAIL mtlo_lo: got %h expected 9abcdef0", bus.lo_o); end
    tests++; if (bus.done_o !== 1'b0) begin fails++; $display("FAIL mt_done: got %b expected 0", bus.done_o); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 3'd0, 32'h3, 32'hFFFFFFFE);
    tick();
    drive(1'b1, 3'd1, 32'hFFFFFFFF, 32'h2);
    for (int c = 0; c < 5; c++) begin
      tests++; if (bus.stall_o !== 1'b1) begin fails++; $display("FAIL b2b_stall[%0d]: got %b expected 1", c, bus.stall_o); end
      tick();
    end
    tests++; if (bus.stall_o !== 1'b0 || bus.done_o !== 1'b1) begin fails++; $display("FAIL b2b_handover: got stall=%b done=%b expected stall=0 done=1", bus.stall_o, bus.done_o); end
    tests++; if (bus.hi_o !== 32'hFFFFFFFF) begin fails++; $display("FAIL b2b_first_hi: got %h expected ffffffff", bus.hi_o); end
    tick();
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    for (int c = 0; c < 5; c++) begin
      tests++; if (bus.busy_o !== 1'b1 || bus.done_o !== 1'b0) begin fails++; $display("FAIL b2b_busy[%0d]: got busy=%b done=%b expected busy=1 done=0", c, bus.busy_o, bus.done_o); end
      tick();
    end
    tests++; if (bus.hi_o !== 32'h1 || bus.lo_o !== 32'hFFFFFFFE) begin fails++; $display("FAIL b2b_second: got hi=%h lo=%h expected hi=00000001 lo=fffffffe", bus.hi_o, bus.lo_o); end
    tick();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 3'd2, 32'h7, 32'hFFFFFFFE);
    tick();
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    tests++; if (bus.hi_o !== 32'h0 || bus.lo_o !== 32'h0) begin fails++; $display("FAIL rst_mid_hilo: got hi=%h lo=%h expected 0", bus.hi_o, bus.lo_o); end
    tests++; if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin fails++; $display("FAIL rst_mid_flags: got busy=%b done=%b expected 0", bus.busy_o, bus.done_o); end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tests++; if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) begin fails++; $display("FAIL rst_mid_after[%0d]: got busy=%b done=%b expected 0", c, bus.busy_o, bus.done_o); end
      tick();
    end
    tests++; if (bus.hi_o !== 32'h0 || bus.lo_o !== 32'h0) begin fails++; $display("FAIL rst_mid_final: got hi=%h lo=%h expected 0", bus.hi_o, bus.lo_o); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_arith();
    test_mf_stall();
    test_mt();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
